// File: rtl/mem_pkg.sv
// Shared decode constants, funct3 encodings and FSM states for the data-memory access path.
// Latency: n/a (declarations and one pure combinational helper).
// Backpressure: n/a.
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_f3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Access size lives in funct3[1:0] for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_aligned = ~off[0];
      2'b10:   is_aligned = (off == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword/word lane of read data and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = mem_rdata >> {offset, 3'b000};

  // Extend the low bits of the shifted lane according to the load type.
  always_comb begin
    result = lane;
    case (funct3)
      LD_LB:   result = {{24{lane[7]}}, lane[7:0]};
      LD_LH:   result = {{16{lane[15]}}, lane[15:0]};
      LD_LBU:  result = {24'd0, lane[7:0]};
      LD_LHU:  result = {16'd0, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one registered data-memory request per memory instruction.
// Latency: 3 cycles minimum (IDLE issue, WAIT until ack or timeout, DONE write-back).
// Backpressure: stall holds the upstream pipeline while a request is outstanding; misaligned ops never issue.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] rd2,
  input  logic [31:0] inst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem, aligned;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        issue, ack_seen, timeout;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] load_q, load_ext;
  logic        bus_err_q;
  logic        unused_inst;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign is_mem      = is_load | is_store;
  assign aligned     = is_aligned(funct3, alu_result[1:0]);
  assign unused_inst = ^{inst[31:15], inst[11:7]};

  // Classify the MEM-stage instruction; unknown funct3 values fall through as non-memory.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OP_LOAD) begin
      case (funct3)
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: is_load = 1'b1;
        default:                             is_load = 1'b0;
      endcase
    end
    if (opcode == OP_STORE) begin
      case (funct3)
        ST_SB, ST_SH, ST_SW: is_store = 1'b1;
        default:             is_store = 1'b0;
      endcase
    end
  end

  // Build byte enables and lane-replicated write data; loads carry no enables.
  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = rd2;
    if (is_store) begin
      case (funct3)
        ST_SB: begin
          req_wstrb = 4'b0001 << alu_result[1:0];
          req_wdata = {4{rd2[7:0]}};
        end
        ST_SH: begin
          req_wstrb = 4'b0011 << alu_result[1:0];
          req_wdata = {2{rd2[15:0]}};
        end
        default: req_wstrb = 4'b1111;
      endcase
    end
  end

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .result    (load_ext)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and pipeline-facing outputs; reset forces a transparent, non-stalling view.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    wb_data    = alu_result;
    misaligned = 1'b0;
    issue      = 1'b0;
    ack_seen   = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mem) begin
          if (aligned) begin
            stall     = 1'b1;
            issue     = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            misaligned = 1'b1;
            wb_data    = 32'd0;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          ack_seen  = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        wb_data   = mem_we ? alu_result : load_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst) begin
      stall      = 1'b0;
      wb_data    = alu_result;
      misaligned = 1'b0;
    end
  end

  assign bus_err = bus_err_q & ~rst;

  // Request fields are latched at issue and held until the next issue; only mem_req drops on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
      cnt       <= 8'd0;
      load_q    <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {alu_result[31:2], 2'b00};
        mem_wdata <= req_wdata;
        mem_wstrb <= req_wstrb;
        off_q     <= alu_result[1:0];
        f3_q      <= funct3;
        cnt       <= 8'd0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 8'd1;
        if (ack_seen) begin
          mem_req <= 1'b0;
          load_q  <= load_ext;
        end else if (timeout) begin
          mem_req <= 1'b0;
          load_q  <= 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: transaction-level model predicts per-cycle outputs, one compare process checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, rd2, inst;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] wb_data;
  logic        misaligned, bus_err;

  mem_access_unit #(.ACK_TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .rd2        (rd2),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .wb_data    (wb_data),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // expectations written by the driver, consumed by the compare process
  logic        chk_en = 1'b0, chk_req = 1'b0, chk_wb = 1'b0, chk_fields = 1'b0;
  logic        exp_stall, exp_mis, exp_berr, exp_req, exp_we;
  logic [31:0] exp_wb, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  // per-operation observations used by the directed literal checks
  int          cap_stall;
  logic        cap_req_seen, cap_mis, cap_berr, cap_we;
  logic [31:0] cap_addr, cap_wdata, cap_done_wb;
  logic [3:0]  cap_wstrb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
    end
  endtask

  // 0 = non-memory, 1 = load, 2 = store
  function automatic int op_kind(input logic [31:0] i);
    logic [2:0] f;
    f = i[14:12];
    if (i[6:0] == 7'b0000011 && f != 3'd3 && f != 3'd6 && f != 3'd7) return 1;
    if (i[6:0] == 7'b0100011 && f < 3'd3) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input int off, input logic [2:0] f);
    int nbytes;
    logic [31:0] v, mask;
    nbytes = 1 << f[1:0];
    v = rd >> (8 * off);
    if (nbytes < 4) begin
      mask = (32'd1 << (8 * nbytes)) - 32'd1;
      v = v & mask;
      if (f[2] == 1'b0 && v[8*nbytes-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Compare process: every cycle the driver marks as meaningful.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      check("bus_err", {31'd0, bus_err}, {31'd0, exp_berr});
      if (chk_req) check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (chk_wb) check("wb_data", wb_data, exp_wb);
      if (chk_fields) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    if (stall) cap_stall++;
    if (mem_req) cap_req_seen = 1'b1;
    if (misaligned) cap_mis = 1'b1;
    if (bus_err) cap_berr = 1'b1;
  endtask

  // One instruction through the MEM stage; ack_at = WAIT cycle carrying the ack (0 or >T: none).
  task automatic run_op(input logic [31:0] i_inst, input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rdata);
    int kind, size, off;
    bit mis, acked;
    kind  = op_kind(i_inst);
    size  = 1 << i_inst[13:12];
    off   = int'(a % 4);
    mis   = (kind != 0) && ((a % size) != 0);
    acked = (ack_at >= 1) && (ack_at <= T);
    cap_stall = 0; cap_req_seen = 1'b0; cap_mis = 1'b0; cap_berr = 1'b0; cap_done_wb = 32'd0;
    step();
    inst = i_inst; alu_result = a; rd2 = d;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    exp_stall = (kind != 0) && !mis; exp_mis = mis; exp_berr = 1'b0;
    exp_req = 1'b0; chk_req = 1'b1; chk_fields = 1'b0;
    chk_wb = (kind == 0) || mis; exp_wb = mis ? 32'd0 : a;
    sample();
    if (kind == 0 || mis) return;
    exp_we    = (kind == 2);
    exp_addr  = a & ~32'd3;
    exp_wstrb = (kind == 2) ? 4'(((1 << size) - 1) << off) : 4'd0;
    for (int b = 0; b < 4; b++) exp_wdata[8*b +: 8] = d[8*(b % size) +: 8];
    for (int j = 1; j <= T; j++) begin
      step();
      mem_ack = (j == ack_at); mem_rdata = (j == ack_at) ? rdata : $urandom;
      exp_stall = 1'b1; exp_mis = 1'b0; exp_req = 1'b1; chk_fields = 1'b1; chk_wb = 1'b0;
      sample();
      if (j == 1) begin
        cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
      end
      if (j == ack_at) break;
    end
    step();
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    exp_stall = 1'b0; exp_req = 1'b0; chk_fields = 1'b0; exp_berr = !acked; chk_wb = 1'b1;
    exp_wb = (kind == 2) ? a : (acked ? model_load(rdata, off, i_inst[14:12]) : 32'd0);
    sample();
    cap_done_wb = wb_data;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] v;
    v = 32'h0;
    v[6:0] = opc;
    v[14:12] = f3;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  lf3 [0:4];
    logic [31:0] ri, ra;
    int          sel;
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;

    // reset: transparent outputs, then all request fields zero
    rst = 1'b1; inst = 32'h0; alu_result = 32'h1234; rd2 = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_req = 1'b0;
    chk_wb = 1'b1; exp_wb = 32'h1234; chk_req = 1'b0; chk_fields = 1'b0; chk_en = 1'b1;
    step();
    chk_req = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'h0);
    check("rst_we", {31'd0, mem_we}, 32'h0);

    // pin the model with hand-computed values
    check("model_lb", model_load(32'h80123456, 3, 3'b000), 32'hFFFFFF80);
    check("model_lhu", model_load(32'h8001ABCD, 2, 3'b101), 32'h00008001);

    // LW at 0x100, ack on the second WAIT cycle
    run_op(mk(7'b0000011, 3'b010), 32'h100, 32'h0, 2, 32'hDEADBEEF);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_wstrb", {28'd0, cap_wstrb}, 32'h0);
    check("lw_stall_cycles", cap_stall, 3);
    check("lw_wb", cap_done_wb, 32'hDEADBEEF);

    run_op(mk(7'b0000011, 3'b000), 32'h103, 32'h0, 1, 32'h80123456);
    check("lb_wb", cap_done_wb, 32'hFFFFFF80);
    run_op(mk(7'b0000011, 3'b100), 32'h103, 32'h0, 3, 32'h80123456);
    check("lbu_wb", cap_done_wb, 32'h00000080);
    run_op(mk(7'b0000011, 3'b001), 32'h102, 32'h0, 1, 32'h80017777);
    check("lh_wb", cap_done_wb, 32'hFFFF8001);

    run_op(mk(7'b0100011, 3'b000), 32'h201, 32'h123456AB, 1, 32'h0);
    check("sb_addr", cap_addr, 32'h200);
    check("sb_wstrb", {28'd0, cap_wstrb}, 32'h2);
    check("sb_wdata", cap_wdata, 32'hABABABAB);
    check("sb_we", {31'd0, cap_we}, 32'h1);
    run_op(mk(7'b0100011, 3'b001), 32'h202, 32'h123456AB, 2, 32'h0);
    check("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
    check("sh_wb", cap_done_wb, 32'h202);

    run_op(mk(7'b0000011, 3'b010), 32'h102, 32'h0, 1, 32'h0);
    check("mis_pulse", {31'd0, cap_mis}, 32'h1);
    check("mis_no_req", {31'd0, cap_req_seen}, 32'h0);
    check("mis_no_stall", cap_stall, 0);
    run_op(32'h00000033, 32'h5555, 32'h0, 0, 32'h0);
    check("add_no_stall", cap_stall, 0);

    // no ack at all: timeout
    run_op(mk(7'b0000011, 3'b010), 32'h400, 32'h0, 0, 32'h0);
    check("to_berr", {31'd0, cap_berr}, 32'h1);
    check("to_wb", cap_done_wb, 32'h0);
    check("to_stall_cycles", cap_stall, T + 1);

    // reset while WAITing, then a late ack
    step();
    inst = mk(7'b0000011, 3'b010); alu_result = 32'h300; mem_ack = 1'b0;
    exp_stall = 1'b1; exp_mis = 1'b0; exp_berr = 1'b0; exp_req = 1'b0; chk_wb = 1'b0; chk_fields = 1'b0;
    step();
    exp_req = 1'b1;
    step();
    rst = 1'b1; exp_stall = 1'b0; chk_req = 1'b0; chk_wb = 1'b1; exp_wb = 32'h300;
    step();
    rst = 1'b0; inst = 32'h00000033; alu_result = 32'h777; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    chk_req = 1'b1; exp_req = 1'b0; exp_wb = 32'h777;
    @(negedge clk);
    check("rstwait_addr", mem_addr, 32'h0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("rstwait_wb", wb_data, 32'h777);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      ri  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        ri[6:0] = 7'b0000011; ri[14:12] = lf3[$urandom_range(0, 4)];
      end else if (sel < 7) begin
        ri[6:0] = 7'b0100011; ri[14:12] = 3'($urandom_range(0, 2));
      end else if (sel == 7) begin
        ri[6:0] = 7'b0000011; ri[14:12] = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd6;
      end else if (sel == 8) begin
        ri[6:0] = 7'b0100011; ri[14:12] = 3'($urandom_range(3, 7));
      end else begin
        ri[6:0] = 7'b0110011;
      end
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_op(ri, ra, $urandom, $urandom_range(1, 20), $urandom);
    end

    chk_en = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, number of WAIT cycles without mem_ack before abort (range 2..255).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alu_result  in  32  effective address for loads/stores; pass-through value for non-memory instructions (from EX/MEM register).
REQ-005 rd2  in  32  store source data (from EX/MEM register).
REQ-006 inst  in  32  instruction in MEM stage (from EX/MEM register).
REQ-007 mem_req  out  1  data-memory request, registered.
REQ-008 mem_we  out  1  1 = store, 0 = load; valid while mem_req=1.
REQ-009 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-010 mem_wdata  out  32  lane-replicated store data.
REQ-011 mem_wstrb  out  4  byte enables; 4'b0000 for loads.
REQ-012 mem_ack  in  1  memory completion, one-cycle pulse.
REQ-013 mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-014 stall  out  1  freezes IF/ID/EX and EX/MEM registers.
REQ-015 wb_data  out  32  write-back value.
REQ-016 misaligned  out  1  one-cycle pulse on misaligned access.
REQ-017 bus_err  out  1  one-cycle pulse on ack timeout.

Function
REQ-018 Decode: opcode inst[6:0]=0000011 is a load, 0100011 is a store; funct3=inst[14:12]; loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010; any other funct3 or opcode is non-memory.
REQ-019 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-020 IDLE + non-memory: stall=0, wb_data=alu_result, stay IDLE.
REQ-021 IDLE + aligned memory op: stall=1 combinationally; next edge registers mem_req=1, mem_we, mem_addr, mem_wdata, mem_wstrb, byte offset and funct3 -> WAIT.
REQ-022 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; byte always aligned.
REQ-023 IDLE + misaligned op: no request; misaligned=1 that cycle; stall=0; wb_data=0; stay IDLE.
REQ-024 WAIT: stall=1; mem_req and all request fields held stable until mem_ack; timeout counter increments each cycle.
REQ-025 WAIT + mem_ack: capture extracted load data; mem_req=0 next edge -> DONE.
REQ-026 WAIT + counter reaching ACK_TIMEOUT without mem_ack: mem_req=0, bus_err=1 for one cycle, load data 0 -> DONE.
REQ-027 DONE: stall=0; wb_data = captured load data (loads) or alu_result (stores); unconditionally -> IDLE next edge, so the same instruction is never reissued.
REQ-028 Stores: SB wstrb=4'b0001<<off, wdata={4{rd2[7:0]}}; SH wstrb=4'b0011<<off, wdata={2{rd2[15:0]}}; SW wstrb=4'b1111, wdata=rd2.
REQ-029 Loads: lane = mem_rdata >> (8*off); LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-030 mem_ack while in IDLE or DONE is ignored.
REQ-031 Minimum latency per memory op: 3 cycles (IDLE, WAIT with ack, DONE).

Reset
REQ-032 rst in any state: next edge IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, counter=0, captured data=0.
REQ-033 During and directly after reset: stall=0, wb_data=alu_result, misaligned=0, bus_err=0; an ack arriving after reset mid-WAIT is ignored.

Structure
REQ-034 Package mem_pkg holds opcode constants, load/store funct3 enums and the FSM state enum.
REQ-035 One combinational sub-module, load_extend (mem_rdata, offset, funct3 -> 32-bit result), implements REQ-029.

Verification
REQ-036 LW addr 0x100, ack on 2nd WAIT cycle, rdata 0xDEADBEEF -> mem_addr=0x100, wstrb=0, stall for 3 cycles, wb_data=0xDEADBEEF in DONE.
REQ-037 LB addr 0x103, rdata 0x80xxxxxx -> wb_data=0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102, rdata 0x8001xxxx -> 0xFFFF8001.
REQ-038 SB addr 0x201, rd2=0x123456AB -> mem_addr=0x200, wstrb=0010, wdata=0xABABABAB, mem_we=1; SH addr 0x202 -> wstrb=1100.
REQ-039 LW addr 0x102 -> misaligned pulse, mem_req never asserted, stall=0; add, then an ADD -> wb_data=alu_result, stall=0.
REQ-040 No ack for ACK_TIMEOUT=16 cycles -> bus_err pulse, mem_req drops, DONE with wb_data=0, then IDLE.
REQ-041 rst in WAIT, ack one cycle later -> IDLE, mem_req=0, no DONE cycle, no wb_data change.
